// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the fetch queue unit and its queue storage.
// Holds the default address width, instruction word width, the canonical
// NOP encoding and the packed fetch-entry layout {pc, instr} that travels
// from the fetch PC register through the queue to decode.
package rv_fetch_pkg;

   localparam int XLEN_DEF = 64;
   localparam int INSTR_W  = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [INSTR_W-1:0]  instr;
   } fetch_entry_t;

   // Width of one queue entry for a given address width.
   function automatic int entryWidth(input int xlen);
      return xlen + INSTR_W;
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous FIFO holding fetched {pc, instr} entries.
// Flush has priority over push and pop and empties the queue in one edge.
// When full, a push is accepted only if a pop happens in the same cycle,
// so the slot being read out is reused by the incoming entry.
// The head is shown combinationally on dout and reads as zero when empty.
module ifq_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rdPtr;
   logic [PW-1:0]    r_wrPtr;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign full  = (r_count == CW'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;

   // A pop needs something to pop; a push needs room, which a same-cycle
   // pop provides. Flush overrides both so a redirect never leaks entries.
   assign w_doPop  = pop  & ~flush & ~empty;
   assign w_doPush = push & ~flush & (~full | w_doPop);

   assign dout = empty ? '0 : r_mem[r_rdPtr];

   // Entry storage needs no reset: an entry is only ever visible after it
   // has been written, and the empty head is masked to zero above.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= din;
      end
   end

   // Pointers and occupancy. Pointers are log2(DEPTH) bits so they wrap on
   // their own; occupancy moves only when exactly one of push/pop happens.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: sequential instruction fetch into an N-entry queue that
// feeds decode over a valid/ready handshake, with branch redirect + flush.
//
// Optional feature, macro FETCH_MISALIGN_CHECK_EN:
//   defined   - a redirect to a non word-aligned target still flushes and
//               loads the PC, but raises the sticky misalign_err and halts
//               fetching until an aligned redirect or reset.
//   undefined - misalign_err is tied low and fetching never halts; the low
//               PC bits are simply ignored when indexing instruction memory.
//
// The instruction memory image (IMEM_FILE) is placed into r_imem by the
// surrounding flow; this block only reads it combinationally, and addresses
// beyond the image alias back into it modulo IMEM_DEPTH.
module fetch_queue_unit
   import rv_fetch_pkg::*;
#(
   parameter int               XLEN       = XLEN_DEF,
   parameter int               IMEM_DEPTH = 16,
   parameter int               FQ_DEPTH   = 4,
   parameter logic [XLEN-1:0]  RESET_PC   = '0,
   parameter string            IMEM_FILE  = "instructions.hex"
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        redirect,
   input  logic [XLEN-1:0]             redirect_pc,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [XLEN-1:0]             out_pc,
   output logic [INSTR_W-1:0]          out_instr,
   output logic [$clog2(FQ_DEPTH):0]   fq_count,
   output logic                        misalign_err
);

   localparam int IDXW = $clog2(IMEM_DEPTH);
   localparam int EW   = entryWidth(XLEN);

   logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
   logic [XLEN-1:0]    r_fetchPc;
   logic [IDXW-1:0]    w_idx;
   logic [EW-1:0]      w_pushData;
   logic [EW-1:0]      w_headData;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_halted;

   // Word index drops the byte offset; upper PC bits fall away, which is
   // what makes out-of-range addresses alias into the image.
   assign w_idx      = r_fetchPc[IDXW+1:2];
   assign w_pushData = {r_fetchPc, r_imem[w_idx]};

   // Decode takes the head when it is valid and ready. A redirect in the
   // same cycle cancels that pop through the queue flush.
   assign w_pop  = out_valid & out_ready;
   assign w_push = ~redirect & ~w_halted & (~w_full | w_pop);

   assign out_valid = ~w_empty;
   assign out_pc    = w_headData[EW-1:INSTR_W];
   assign out_instr = w_headData[INSTR_W-1:0];

   ifq_fifo #(
      .WIDTH (EW),
      .DEPTH (FQ_DEPTH)
   ) u_ifq_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_push),
      .pop     (w_pop),
      .flush   (redirect),
      .din     (w_pushData),
      .dout    (w_headData),
      .count   (fq_count),
      .full    (w_full),
      .empty   (w_empty)
   );

   // Fetch PC: a redirect loads the branch target outright (last redirect
   // wins when they come back to back); otherwise the PC steps one word
   // every time an instruction is actually pushed into the queue.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fetchPc <= RESET_PC;
      end else if (redirect) begin
         r_fetchPc <= redirect_pc;
      end else if (w_push) begin
         r_fetchPc <= r_fetchPc + XLEN'(4);
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   logic r_misalignErr;
   logic r_halted;

   assign misalign_err = r_misalignErr;
   assign w_halted     = r_halted;

   // Every redirect re-evaluates alignment: a misaligned target raises the
   // error and stops fetching, an aligned one clears both and resumes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_misalignErr <= 1'b0;
         r_halted      <= 1'b0;
      end else if (redirect) begin
         r_misalignErr <= |redirect_pc[1:0];
         r_halted      <= |redirect_pc[1:0];
      end
   end
`else
   assign misalign_err = 1'b0;
   assign w_halted     = 1'b0;
`endif

endmodule
